// File: rtl/iq_interp_out_buffer.sv
// Output buffer for the interpolated I/Q stream: FIFO of I/Q pairs with almost-full
// back-pressure, presented as sign-extended 32-bit words on a valid/ready port.
module iq_interp_out_buffer #(
    parameter int unsigned DATAPATH_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned AF_DIFF        = 2
) (
    input  logic                      clk,
    input  logic                      rst_a,
    input  logic                      write_enable_i,
    input  logic [DATAPATH_WIDTH-1:0] I_interp_i,
    input  logic [DATAPATH_WIDTH-1:0] Q_interp_i,
    input  logic                      clear_i,
    input  logic                      m_ready_i,
    output logic                      m_valid_o,
    output logic [31:0]               m_data_o,
    output logic                      afull_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      ovf_o,
    output logic [ADDR_WIDTH:0]       level_o
);

    localparam int unsigned Depth    = 1 << ADDR_WIDTH;
    localparam int unsigned AfullThr = Depth - AF_DIFF;
    localparam int unsigned MemW     = 2 * DATAPATH_WIDTH;

    localparam logic [ADDR_WIDTH:0] LvlFull  = Depth[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LvlAfull = AfullThr[ADDR_WIDTH:0];

    logic [MemW-1:0]       mem_q [Depth];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           data_q, data_d;

    logic            push;
    logic            load;
    logic            mem_we;
    logic [MemW-1:0] head;

    function automatic logic [15:0] sext16(input logic [DATAPATH_WIDTH-1:0] x);
        logic [15:0] r;
        r = {16{x[DATAPATH_WIDTH-1]}};
        r[DATAPATH_WIDTH-1:0] = x;
        return r;
    endfunction

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        // Room is judged on the pre-edge level; a same-cycle load never frees a slot.
        push     = write_enable_i && (level_q != LvlFull);
        load     = (level_q != '0) && (!valid_q || m_ready_i);
        mem_we   = push && !clear_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        data_d   = data_q;

        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end else if (write_enable_i) begin
                ovf_d = 1'b1;
            end

            if (load) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                valid_d  = 1'b1;
                data_d   = {sext16(head[MemW-1:DATAPATH_WIDTH]),
                            sext16(head[DATAPATH_WIDTH-1:0])};
            end else if (valid_q && m_ready_i) begin
                valid_d = 1'b0;
            end

            case ({push, load})
                2'b10:   level_d = level_q + (ADDR_WIDTH + 1)'(1);
                2'b01:   level_d = level_q - (ADDR_WIDTH + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
        end
    end

    // Memory contents need no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {Q_interp_i, I_interp_i};
        end
    end

    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;
    assign ovf_o     = ovf_q;
    assign level_o   = level_q;
    assign full_o    = (level_q == LvlFull);
    assign empty_o   = (level_q == '0);
    assign afull_o   = (level_q >= LvlAfull);

endmodule

// File: tb/tb_iq_interp_out_buffer.sv
// Randomized self-checking bench for iq_interp_out_buffer against a queue-based model.
module tb_iq_interp_out_buffer;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        we = 1'b0;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;
    logic [11:0] i_s = '0;
    logic [11:0] q_s = '0;

    logic        m_valid_o;
    logic [31:0] m_data_o;
    logic        afull_o;
    logic        full_o;
    logic        empty_o;
    logic        ovf_o;
    logic [3:0]  level_o;

    // Model: words waiting in memory, plus the output register and sticky overflow.
    logic [31:0] fifo[$];
    bit          mv;
    logic [31:0] md;
    bit          movf;

    int n_vec = 0;
    int n_err = 0;

    iq_interp_out_buffer dut (
        .clk            (clk),
        .rst_a          (rst_a),
        .write_enable_i (we),
        .I_interp_i     (i_s),
        .Q_interp_i     (q_s),
        .clear_i        (clr),
        .m_ready_i      (rdy),
        .m_valid_o      (m_valid_o),
        .m_data_o       (m_data_o),
        .afull_o        (afull_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .ovf_o          (ovf_o),
        .level_o        (level_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sx(input logic [11:0] v);
        int s;
        s = int'(v);
        if (s >= 2048) s = s - 4096;
        return 16'(s);
    endfunction

    function automatic logic [31:0] pack(input logic [11:0] iv, input logic [11:0] qv);
        return {sx(qv), sx(iv)};
    endfunction

    task automatic model_reset();
        fifo.delete();
        mv   = 1'b0;
        md   = '0;
        movf = 1'b0;
    endtask

    task automatic step(input bit w, input logic [11:0] iv, input logic [11:0] qv,
                        input bit c, input bit r);
        int lvl;
        we  = w;
        i_s = iv;
        q_s = qv;
        clr = c;
        rdy = r;
        @(posedge clk);
        if (c) begin
            fifo.delete();
            mv   = 1'b0;
            movf = 1'b0;
        end else begin
            lvl = fifo.size();
            if (lvl > 0 && (!mv || r)) begin
                md = fifo.pop_front();
                mv = 1'b1;
            end else if (mv && r) begin
                mv = 1'b0;
            end
            if (w) begin
                if (lvl < 8) fifo.push_back(pack(iv, qv));
                else movf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        model_reset();
        #12;
        n_vec++; if (level_o !== 4'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level_o); end
        n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty_o); end
        n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full_o); end
        n_vec++; if (afull_o !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", afull_o); end
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", m_valid_o); end
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf_o); end
        n_vec++; if (m_data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", m_data_o); end
        @(posedge clk);
        #1;
        rst_a = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 12'h7FF, 12'h800, 1'b0, 1'b1);
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL single_edge1_valid got %b want 0", m_valid_o); end
        n_vec++; if (level_o !== 4'd1) begin n_err++; $display("FAIL single_edge1_level got %0d want 1", level_o); end
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        n_vec++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL single_edge2_valid got %b want 1", m_valid_o); end
        n_vec++; if (m_data_o !== 32'hF80007FF) begin n_err++; $display("FAIL single_data got %h want F80007FF", m_data_o); end
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL single_edge3_valid got %b want 0", m_valid_o); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 12'(k), 12'(-k), 1'b0, 1'b0);
            n_vec++; if (level_o !== 4'(fifo.size())) begin n_err++; $display("FAIL fill_level k=%0d got %0d want %0d", k, level_o, fifo.size()); end
            n_vec++; if (afull_o !== (fifo.size() >= 6)) begin n_err++; $display("FAIL fill_afull k=%0d got %b want %b", k, afull_o, fifo.size() >= 6); end
        end
        n_vec++; if (level_o !== 4'd7) begin n_err++; $display("FAIL fill_level7 got %0d want 7", level_o); end
        step(1'b1, 12'd8, 12'(-8), 1'b0, 1'b0);
        n_vec++; if (full_o !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full_o); end
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL fill_ovf_early got %b want 0", ovf_o); end
        step(1'b1, 12'd9, 12'(-9), 1'b0, 1'b0);
        n_vec++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL fill_ovf got %b want 1", ovf_o); end
        n_vec++; if (level_o !== 4'd8) begin n_err++; $display("FAIL fill_level8 got %0d want 8", level_o); end
    endtask

    task automatic test_drain();
        n_vec++; if (m_data_o !== pack(12'd0, 12'd0)) begin n_err++; $display("FAIL drain_k0 got %h want %h", m_data_o, pack(12'd0, 12'd0)); end
        for (int k = 1; k < 9; k++) begin
            step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
            n_vec++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL drain_valid k=%0d got %b want 1", k, m_valid_o); end
            n_vec++; if (m_data_o !== pack(12'(k), 12'(-k))) begin n_err++; $display("FAIL drain_data k=%0d got %h want %h", k, m_data_o, pack(12'(k), 12'(-k))); end
        end
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_end_valid got %b want 0", m_valid_o); end
        n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL drain_end_empty got %b want 1", empty_o); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) step(1'b1, 12'($urandom), 12'($urandom), 1'b0, 1'b0);
        n_vec++; if (level_o !== 4'd3) begin n_err++; $display("FAIL b2b_start_level got %0d want 3", level_o); end
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 12'($urandom), 12'($urandom), 1'b0, 1'b1);
            n_vec++; if (level_o !== 4'd3) begin n_err++; $display("FAIL b2b_level c=%0d got %0d want 3", k, level_o); end
            n_vec++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid c=%0d got %b want 1", k, m_valid_o); end
            n_vec++; if (m_data_o !== md) begin n_err++; $display("FAIL b2b_data c=%0d got %h want %h", k, m_data_o, md); end
        end
    endtask

    task automatic test_hold_clear();
        logic [31:0] held;
        held = md;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 12'h0, 12'h0, 1'b0, 1'b0);
            n_vec++; if (m_data_o !== held) begin n_err++; $display("FAIL hold_data c=%0d got %h want %h", k, m_data_o, held); end
            n_vec++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_valid c=%0d got %b want 1", k, m_valid_o); end
        end
        n_vec++; if (ovf_o !== movf) begin n_err++; $display("FAIL hold_ovf got %b want %b", ovf_o, movf); end
        step(1'b1, 12'($urandom), 12'($urandom), 1'b1, 1'b0);
        n_vec++; if (level_o !== 4'd0) begin n_err++; $display("FAIL clear_level got %0d want 0", level_o); end
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL clear_valid got %b want 0", m_valid_o); end
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL clear_ovf got %b want 0", ovf_o); end
        n_vec++; if (m_data_o !== held) begin n_err++; $display("FAIL clear_data got %h want %h", m_data_o, held); end
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        n_vec++; if (level_o !== 4'd0) begin n_err++; $display("FAIL clear_push_dropped got %0d want 0", level_o); end
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL clear_after_valid got %b want 0", m_valid_o); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] ri, rq;
        for (int k = 0; k < 6; k++) step(1'b1, 12'($urandom), 12'($urandom), 1'b0, 1'b0);
        n_vec++; if (level_o !== 4'd5) begin n_err++; $display("FAIL rmid_pre_level got %0d want 5", level_o); end
        #2;
        rst_a = 1'b0;
        #1;
        model_reset();
        n_vec++; if (level_o !== 4'd0) begin n_err++; $display("FAIL rmid_level got %0d want 0", level_o); end
        n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL rmid_empty got %b want 1", empty_o); end
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", m_valid_o); end
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        ri = 12'($urandom);
        rq = 12'($urandom);
        step(1'b1, ri, rq, 1'b0, 1'b1);
        n_vec++; if (m_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_edge1_valid got %b want 0", m_valid_o); end
        step(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        n_vec++; if (m_valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_edge2_valid got %b want 1", m_valid_o); end
        n_vec++; if (m_data_o !== pack(ri, rq)) begin n_err++; $display("FAIL rmid_data got %h want %h", m_data_o, pack(ri, rq)); end
    endtask

    task automatic test_random();
        int sz;
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, 12'($urandom), 12'($urandom),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
            sz = fifo.size();
            n_vec++; if (level_o !== 4'(sz)) begin n_err++; $display("FAIL rnd_level c=%0d got %0d want %0d", k, level_o, sz); end
            n_vec++; if (full_o !== (sz == 8)) begin n_err++; $display("FAIL rnd_full c=%0d got %b want %b", k, full_o, sz == 8); end
            n_vec++; if (empty_o !== (sz == 0)) begin n_err++; $display("FAIL rnd_empty c=%0d got %b want %b", k, empty_o, sz == 0); end
            n_vec++; if (afull_o !== (sz >= 6)) begin n_err++; $display("FAIL rnd_afull c=%0d got %b want %b", k, afull_o, sz >= 6); end
            n_vec++; if (m_valid_o !== mv) begin n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", k, m_valid_o, mv); end
            n_vec++; if (m_data_o !== md) begin n_err++; $display("FAIL rnd_data c=%0d got %h want %h", k, m_data_o, md); end
            n_vec++; if (ovf_o !== movf) begin n_err++; $display("FAIL rnd_ovf c=%0d got %b want %b", k, ovf_o, movf); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_hold_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iq_interp_out_buffer.md
# iq_interp_out_buffer

Output buffer for the interpolated I/Q stream, downstream of the interpolator core. It captures `I_interp`/`Q_interp` pairs on the interpolator's write strobe and stores them in a shared FIFO. It drives the almost-full back-pressure that the interpolator samples as `Afull_I_in`/`Afull_Q_in`. It presents each pair as one sign-extended 32-bit word on a valid/ready interface for the bus or DAC side.

## Interface
- `DATAPATH_WIDTH`, 12: width of each I and Q sample, two's complement; must be ≤16.
- `ADDR_WIDTH`, 3: FIFO address bits; DEPTH = 2^ADDR_WIDTH entries.
- `AF_DIFF`, 2: almost-full margin in entries; must be < DEPTH.

- `clk` in 1: single clock, rising edge.
- `rst_a` in 1: reset, asynchronous, active-low.
- `write_enable_i` in 1: push strobe, one I/Q pair per high cycle.
- `I_interp_i` in DATAPATH_WIDTH: I sample.
- `Q_interp_i` in DATAPATH_WIDTH: Q sample.
- `clear_i` in 1: synchronous flush, active-high.
- `m_ready_i` in 1: consumer ready.
- `m_valid_o` out 1: output word valid.
- `m_data_o` out 32: {sext16(Q), sext16(I)}; Q occupies [31:16] and I occupies [15:0].
- `afull_o` out 1: almost-full, fed back to the interpolator.
- `full_o` out 1: FIFO memory full.
- `empty_o` out 1: FIFO memory empty.
- `ovf_o` out 1: sticky overflow, set when a push is dropped.
- `level_o` out ADDR_WIDTH+1: number of entries in memory, excluding the output register.

## Operation
- Storage is a memory of DEPTH × (2·DATAPATH_WIDTH) bits plus one output register holding the word shown on `m_data_o`.
- The write pointer and read pointer are ADDR_WIDTH bits each and wrap modulo DEPTH.
- `level_o` is a counter in the range 0..DEPTH.

Push:
- A push is accepted when `write_enable_i`=1 and `level_o`<DEPTH, both evaluated before the clock edge.
- A push when full is dropped: memory and pointers are unchanged and `ovf_o`←1.
- A pop in the same cycle does not make room for a push when full.

Load:
- The output register loads from the memory head when `level_o`>0 and either `m_valid_o`=0 or (`m_valid_o`=1 and `m_ready_i`=1).
- On a load: read pointer +1, level −1, `m_valid_o`←1, `m_data_o`←packed head word.

Consume:
- A transfer occurs when `m_valid_o`=1 and `m_ready_i`=1.
- If no load happens on that edge, `m_valid_o`←0 and `m_data_o` holds its last value.

Counter and flags:
- A push and a load on the same edge leave `level_o` unchanged.
- `full_o` = (`level_o`==DEPTH).
- `empty_o` = (`level_o`==0).
- `afull_o` = (`level_o` ≥ DEPTH−AF_DIFF).
- All three flags are combinational from the level register.

Packing: each of I and Q is sign-extended from DATAPATH_WIDTH to 16 bits, with no scaling.

Clear:
- `clear_i`=1 zeroes the pointers, `level_o`, `m_valid_o` and `ovf_o`, and discards any push or pop on that edge.
- Clear has priority over all other actions. `m_data_o` is not cleared.

Stability rule: while `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` and `m_valid_o` are held.

Reset (`rst_a`=0, asynchronous):
- Pointers, level, `m_valid_o`, `ovf_o` and `m_data_o` go to 0.
- `afull_o`=0, `full_o`=0, `empty_o`=1.
- Reset asserted mid-burst discards all contents immediately. The first push after release is accepted normally.

## Timing
- Push to `level_o` update: 1 edge.
- Push into an empty buffer with an empty output register: `m_valid_o` goes high after the 2nd edge (edge 1 writes memory, edge 2 loads the output register).
- Sustained throughput is 1 word/cycle when `m_ready_i` is held high.
- `afull_o` asserts on the same edge that brings `level_o` to DEPTH−AF_DIFF. The interpolator sees it one cycle later, so AF_DIFF=2 absorbs one in-flight push plus margin.
- `ovf_o` sets on the edge of the dropped push and stays set until clear or reset.
- `rst_a` is released synchronously to `clk` by the system; the block has no internal synchronizer.

## Test plan
- Reset, then a single push I=0x7FF, Q=0x800 with `m_ready_i`=1 → `m_valid_o`=1 two edges later, `m_data_o`=0xF80007FF, then `m_valid_o`=0.
- `m_ready_i`=0, push 8 pairs (I=k, Q=−k) → `level_o` reaches 7 (one entry sits in the output register) and `afull_o` rises when `level_o`=6. A 9th and 10th push: the 9th fills the memory (`full_o`=1); the 10th is dropped and `ovf_o`=1.
- After the fill, raise `m_ready_i` → 9 words emerge in order k=0..8 with no gaps, the pointers wrap correctly, and `empty_o`=1 at the end.
- `level_o`=3 with simultaneous push and transfer on every cycle for 20 cycles → `level_o` stays at 3, the data sequence is intact, and `m_valid_o` stays continuously high.
- `m_ready_i`=0 with `m_valid_o`=1 for 5 cycles → `m_data_o` is stable. Assert `clear_i` together with `write_enable_i` → `level_o`=0, `m_valid_o`=0, `ovf_o`=0, and the push is discarded.
- Assert `rst_a`=0 mid-stream at `level_o`=5 → outputs immediately show level 0, `empty_o`=1, `m_valid_o`=0. After release, a single push appears at the output after 2 edges.
